// File: rtl/avgpool_2d_stream_if.sv
// Stream bundle for the 2x2 average-pooling stage.
// The pixel input and pooled output handshakes travel together so the stage has one bus port.
interface avgpool_2d_stream_if #(
  parameter int datawidth = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [datawidth-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [datawidth-1:0] out_data;
  logic                 out_last;
  logic                 frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done
  );
endinterface

// File: rtl/avgpool_2d_stream.sv
// 2x2 stride-2 average pooling over a raster-order pixel stream.
// Only a half-width line buffer of horizontal pair sums is kept, never a full frame.
module avgpool_2d_stream #(
  parameter int datawidth  = 32,
  parameter int image_size = 28
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  avgpool_2d_stream_if.slave   bus
);
  localparam int KW       = (image_size > 2) ? $clog2(image_size / 2) : 1;
  localparam int CW       = KW + 1;
  localparam int LB_DEPTH = 1 << KW;
  localparam logic [CW-1:0] LAST_IDX = CW'(image_size - 1);

  generate
    if ((image_size % 2) != 0 || image_size < 2) begin : g_bad_size
      $error("avgpool_2d_stream: image_size must be even and >= 2");
    end
  endgenerate

  // Horizontal pair sum, one bit wider than a pixel so it cannot wrap.
  function automatic logic [datawidth:0] pair_sum(input logic [datawidth-1:0] a,
                                                  input logic [datawidth-1:0] b);
    pair_sum = {a[datawidth-1], a} + {b[datawidth-1], b};
  endfunction

  // Mean of a stored pair plus two new pixels, floored toward -inf.
  function automatic logic [datawidth-1:0] pool_avg(input logic [datawidth:0]   pair,
                                                    input logic [datawidth-1:0] a,
                                                    input logic [datawidth-1:0] b);
    logic [datawidth+1:0] sum;
    sum      = {pair[datawidth], pair} + {{2{a[datawidth-1]}}, a} + {{2{b[datawidth-1]}}, b};
    pool_avg = sum[datawidth+1:2];
  endfunction

  logic [CW-1:0]        row_r;
  logic [CW-1:0]        col_r;
  logic [datawidth-1:0] hold_r;
  logic [datawidth:0]   linebuf_r [LB_DEPTH];
  logic                 out_valid_r;
  logic [datawidth-1:0] out_data_r;
  logic                 out_last_r;
  logic                 frame_done_r;

  logic                 in_ready_s;
  logic                 in_fire_s;
  logic                 out_fire_s;
  logic                 load_s;
  logic                 last_col_s;
  logic                 last_row_s;
  logic [KW-1:0]        k_s;
  logic [CW-1:0]        row_nxt_s;
  logic [CW-1:0]        col_nxt_s;

  assign in_ready_s = enable & (~out_valid_r | bus.out_ready);
  assign in_fire_s  = bus.in_valid & in_ready_s;
  // Output state is frozen while disabled, so a handshake only completes when enabled.
  assign out_fire_s = out_valid_r & bus.out_ready & enable;
  assign last_col_s = (col_r == LAST_IDX);
  assign last_row_s = (row_r == LAST_IDX);
  assign k_s        = col_r[CW-1:1];
  assign load_s     = in_fire_s & row_r[0] & col_r[0];

  // Raster position advance; both counters wrap together at the frame's last pixel.
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
    if (in_fire_s) begin
      if (last_col_s) begin
        col_nxt_s = {CW{1'b0}};
        if (last_row_s) begin
          row_nxt_s = {CW{1'b0}};
        end else begin
          row_nxt_s = row_r + CW'(1);
        end
      end else begin
        col_nxt_s = col_r + CW'(1);
      end
    end else begin
      row_nxt_s = row_r;
      col_nxt_s = col_r;
    end
  end

  // Position, left-pixel hold and output register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_r        <= {CW{1'b0}};
      col_r        <= {CW{1'b0}};
      hold_r       <= {datawidth{1'b0}};
      out_valid_r  <= 1'b0;
      out_data_r   <= {datawidth{1'b0}};
      out_last_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      row_r        <= row_nxt_s;
      col_r        <= col_nxt_s;
      frame_done_r <= out_fire_s & out_last_r;
      if (in_fire_s && !col_r[0]) begin
        hold_r <= bus.in_data;
      end
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= pool_avg(linebuf_r[k_s], hold_r, bus.in_data);
        out_last_r  <= last_row_s & last_col_s;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Line buffer of top-row pair sums; every entry is written before its odd row reads it.
  always_ff @(posedge clk) begin
    if (in_fire_s && !row_r[0] && col_r[0]) begin
      linebuf_r[k_s] <= pair_sum(hold_r, bus.in_data);
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_last   = out_last_r;
  assign bus.frame_done = frame_done_r;
endmodule
